wb_stage: RTL and testbench

Final (writeback) stage of the five-stage MIPS pipeline, directly downstream of the memory stage. It accepts the memory-to-writeback bus and commits register-file writes. It owns the CP0 register file (Status, Cause, EPC, Count, Compare) and executes MTC0/MFC0. It also commits exceptions, raising a flush with the handler PC, and drives the debug trace ports.

---
 rtl/wb_stage_if.sv | 38 +++
 rtl/wb_stage.sv | 264 ++++++++++++++++++++++++++
 tb/tb_wb_stage.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// -----------------------------------------------------------------------------
// wb_stage_if
//   Memory-to-writeback handshake bundle.
//
//   ms_to_ws_valid  upstream (memory stage) holds a valid instruction
//   ms_to_ws_bus    147-bit instruction bus, field layout (msb first):
//                     [146]     mtc0_we
//                     [145:141] cp0_addr
//                     [140]     res_from_cp0
//                     [139:108] alu_result
//                     [107]     ex
//                     [106:102] excode
//                     [101]     gr_we
//                     [100:96]  dest
//                     [95:64]   final_result
//                     [63:32]   rt_value
//                     [31:0]    pc
//   ws_allowin      writeback stage can take a new instruction
//
//   master: memory stage side, slave: writeback stage side.
// -----------------------------------------------------------------------------
interface wb_stage_if;
   logic         ms_to_ws_valid;
   logic [146:0] ms_to_ws_bus;
   logic         ws_allowin;

   modport master (
      output ms_to_ws_valid,
      output ms_to_ws_bus,
      input  ws_allowin
   );

   modport slave (
      input  ms_to_ws_valid,
      input  ms_to_ws_bus,
      output ws_allowin
   );
endinterface

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
//   Writeback stage of the five-stage MIPS pipeline. Registers the
//   memory-to-writeback bus, commits register-file writes, owns the CP0
//   registers (Status, Cause, EPC, Count, Compare) executing MTC0/MFC0,
//   commits exceptions (flush + handler PC) and drives the debug trace.
//
//   Ports
//     clk                single clock, all state on posedge
//     reset              synchronous, active-high
//     ms                 memory-to-writeback handshake (slave side)
//     rf_we/waddr/wdata  register-file write port
//     ws_ex              exception committed this cycle (flush upstream)
//     ws_ex_pc           exception handler address
//     int_req            pending enabled interrupt (level)
//     debug_wb_*         trace port mirroring the committed write
// -----------------------------------------------------------------------------
module wb_stage (
   input  logic        clk,
   input  logic        reset,
   wb_stage_if.slave   ms,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        ws_ex,
   output logic [31:0] ws_ex_pc,
   output logic        int_req,
   output logic [31:0] debug_wb_pc,
   output logic [3:0]  debug_wb_rf_wen,
   output logic [4:0]  debug_wb_rf_wnum,
   output logic [31:0] debug_wb_rf_wdata
);

   localparam int          MS_TO_WS_BUS_WD = 147;
   localparam logic [31:0] EX_HANDLER_PC   = 32'hbfc00380;

   // CP0 register numbers
   localparam logic [4:0] CP0_COUNT   = 5'd9;
   localparam logic [4:0] CP0_COMPARE = 5'd11;
   localparam logic [4:0] CP0_STATUS  = 5'd12;
   localparam logic [4:0] CP0_CAUSE   = 5'd13;
   localparam logic [4:0] CP0_EPC     = 5'd14;

   // ---------------------------------------------------------------------------
   // Handshake and bus register
   // ---------------------------------------------------------------------------
   logic                       ws_valid;
   logic                       ws_ready_go;
   logic                       ws_allowin;
   logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus_r;

   assign ws_ready_go   = 1'b1;
   assign ws_allowin    = !ws_valid || ws_ready_go;
   assign ms.ws_allowin = ws_allowin;

   always_ff @(posedge clk) begin
      if (reset) begin
         ws_valid <= 1'b0;
      end else if (ws_allowin) begin
         ws_valid <= ms.ms_to_ws_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ms_to_ws_bus_r <= '0;
      end else if (ms.ms_to_ws_valid && ws_allowin) begin
         ms_to_ws_bus_r <= ms.ms_to_ws_bus;
      end
   end

   // Bus field unpack
   logic        ws_mtc0_we;
   logic [4:0]  ws_cp0_addr;
   logic        ws_res_from_cp0;
   logic        ws_ex_flag;
   logic [4:0]  ws_excode;
   logic        ws_gr_we;
   logic [4:0]  ws_dest;
   logic [31:0] ws_final_result;
   logic [31:0] ws_rt_value;
   logic [31:0] ws_pc;

   assign ws_mtc0_we      = ms_to_ws_bus_r[146];
   assign ws_cp0_addr     = ms_to_ws_bus_r[145:141];
   assign ws_res_from_cp0 = ms_to_ws_bus_r[140];
   assign ws_ex_flag      = ms_to_ws_bus_r[107];
   assign ws_excode       = ms_to_ws_bus_r[106:102];
   assign ws_gr_we        = ms_to_ws_bus_r[101];
   assign ws_dest         = ms_to_ws_bus_r[100:96];
   assign ws_final_result = ms_to_ws_bus_r[95:64];
   assign ws_rt_value     = ms_to_ws_bus_r[63:32];
   assign ws_pc           = ms_to_ws_bus_r[31:0];

   // alu_result travels on the bus but is not consumed in this stage.
   logic unused_alu_result;
   assign unused_alu_result = ^ms_to_ws_bus_r[139:108];

   // ---------------------------------------------------------------------------
   // Commit qualifiers
   // ---------------------------------------------------------------------------
   logic ex_c;
   logic cp0_we;
   logic we_status, we_cause, we_epc, we_count, we_compare;

   assign ex_c   = ws_valid && ws_ex_flag;
   // An excepting instruction never reaches the register file or CP0.
   assign cp0_we = ws_valid && ws_mtc0_we && !ws_ex_flag;

   assign we_status  = cp0_we && (ws_cp0_addr == CP0_STATUS);
   assign we_cause   = cp0_we && (ws_cp0_addr == CP0_CAUSE);
   assign we_epc     = cp0_we && (ws_cp0_addr == CP0_EPC);
   assign we_count   = cp0_we && (ws_cp0_addr == CP0_COUNT);
   assign we_compare = cp0_we && (ws_cp0_addr == CP0_COMPARE);

   // ---------------------------------------------------------------------------
   // CP0 Status: only IM, EXL, IE are stored; BEV reads as constant 1.
   // ---------------------------------------------------------------------------
   logic [7:0] status_im;
   logic       status_exl;
   logic       status_ie;

   always_ff @(posedge clk) begin
      if (reset) begin
         status_im  <= 8'd0;
         status_exl <= 1'b0;
         status_ie  <= 1'b0;
      end else begin
         if (we_status) begin
            status_im  <= ws_rt_value[15:8];
            status_exl <= ws_rt_value[1];
            status_ie  <= ws_rt_value[0];
         end
         // ex_c and we_status are mutually exclusive by construction.
         if (ex_c) begin
            status_exl <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Timer: tick halves the core clock for Count.
   // ---------------------------------------------------------------------------
   logic        tick;
   logic [31:0] cp0_count;
   logic [31:0] cp0_compare;

   always_ff @(posedge clk) begin
      if (reset) begin
         tick <= 1'b0;
      end else begin
         tick <= ~tick;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cp0_count <= 32'd0;
      end else if (we_count) begin
         // Software write replaces any increment due this cycle.
         cp0_count <= ws_rt_value;
      end else if (tick) begin
         cp0_count <= cp0_count + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cp0_compare <= 32'd0;
      end else if (we_compare) begin
         cp0_compare <= ws_rt_value;
      end
   end

   // ---------------------------------------------------------------------------
   // CP0 Cause: TI (mirrored onto IP[7]), software IP[1:0], ExcCode.
   // BD is never set and IP[6:2] has no source, so neither is stored.
   // ---------------------------------------------------------------------------
   logic       cause_ti;
   logic [1:0] cause_ip_sw;
   logic [4:0] cause_excode;

   always_ff @(posedge clk) begin
      if (reset) begin
         cause_ti <= 1'b0;
      end else if (we_compare) begin
         // Clearing on a Compare write beats a match in the same cycle.
         cause_ti <= 1'b0;
      end else if (cp0_count == cp0_compare) begin
         cause_ti <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cause_ip_sw  <= 2'b00;
         cause_excode <= 5'd0;
      end else begin
         if (we_cause) begin
            cause_ip_sw <= ws_rt_value[9:8];
         end
         if (ex_c) begin
            cause_excode <= ws_excode;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // CP0 EPC
   // ---------------------------------------------------------------------------
   logic [31:0] cp0_epc;

   always_ff @(posedge clk) begin
      if (reset) begin
         cp0_epc <= 32'd0;
      end else if (ex_c) begin
         cp0_epc <= ws_pc;
      end else if (we_epc) begin
         cp0_epc <= ws_rt_value;
      end
   end

   // ---------------------------------------------------------------------------
   // Architectural views and MFC0 read mux
   // ---------------------------------------------------------------------------
   logic [31:0] cp0_status;
   logic [31:0] cp0_cause;
   logic [7:0]  cause_ip;
   logic [31:0] cp0_rdata;

   assign cp0_status = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
   assign cause_ip   = {cause_ti, 5'd0, cause_ip_sw};
   assign cp0_cause  = {1'b0, cause_ti, 14'd0, cause_ip, 1'b0, cause_excode, 2'b00};

   always_comb begin
      cp0_rdata = 32'd0;
      case (ws_cp0_addr)
         CP0_COUNT:   cp0_rdata = cp0_count;
         CP0_COMPARE: cp0_rdata = cp0_compare;
         CP0_STATUS:  cp0_rdata = cp0_status;
         CP0_CAUSE:   cp0_rdata = cp0_cause;
         CP0_EPC:     cp0_rdata = cp0_epc;
         default:     cp0_rdata = 32'd0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign rf_we    = ws_valid && ws_gr_we && !ws_ex_flag;
   assign rf_waddr = ws_dest;
   assign rf_wdata = ws_res_from_cp0 ? cp0_rdata : ws_final_result;

   assign ws_ex    = ex_c;
   assign ws_ex_pc = EX_HANDLER_PC;

   assign int_req  = status_ie && !status_exl && |(cause_ip & status_im);

   assign debug_wb_pc       = ws_pc;
   assign debug_wb_rf_wen   = {4{rf_we}};
   assign debug_wb_rf_wnum  = rf_waddr;
   assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   wb_stage_if bus ();

   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        ws_ex;
   logic [31:0] ws_ex_pc;
   logic        int_req;
   logic [31:0] debug_wb_pc;
   logic [3:0]  debug_wb_rf_wen;
   logic [4:0]  debug_wb_rf_wnum;
   logic [31:0] debug_wb_rf_wdata;

   wb_stage dut (
      .clk               (clk),
      .reset             (reset),
      .ms                (bus),
      .rf_we             (rf_we),
      .rf_waddr          (rf_waddr),
      .rf_wdata          (rf_wdata),
      .ws_ex             (ws_ex),
      .ws_ex_pc          (ws_ex_pc),
      .int_req           (int_req),
      .debug_wb_pc       (debug_wb_pc),
      .debug_wb_rf_wen   (debug_wb_rf_wen),
      .debug_wb_rf_wnum  (debug_wb_rf_wnum),
      .debug_wb_rf_wdata (debug_wb_rf_wdata)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: the instruction sitting in writeback plus full
   // 32-bit architectural CP0 images updated with masks.
   logic         m_valid;
   logic [146:0] m_bus;
   logic [31:0]  m_status, m_cause, m_epc, m_count, m_compare;
   logic         m_tick;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [146:0] mk(input logic mtc0, input logic [4:0] addr,
         input logic rcp0, input logic [31:0] alu, input logic ex, input logic [4:0] exc,
         input logic gwe, input logic [4:0] dest, input logic [31:0] fin,
         input logic [31:0] rt, input logic [31:0] pc);
      return {mtc0, addr, rcp0, alu, ex, exc, gwe, dest, fin, rt, pc};
   endfunction

   function automatic logic [31:0] cp0_read(input logic [4:0] a);
      case (a)
         5'd9:    return m_count;
         5'd11:   return m_compare;
         5'd12:   return m_status;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_edge(input logic rst, input logic v, input logic [146:0] b);
      logic        exc, wr, match;
      logic [4:0]  a;
      logic [31:0] wd, n_count;
      if (rst) begin
         m_valid = 1'b0; m_bus = '0; m_status = 32'h00400000; m_cause = 32'd0;
         m_epc = 32'd0; m_count = 32'd0; m_compare = 32'd0; m_tick = 1'b0;
         return;
      end
      exc     = m_valid && m_bus[107];
      wr      = m_valid && m_bus[146] && !m_bus[107];
      a       = m_bus[145:141];
      wd      = m_bus[63:32];
      match   = (m_count == m_compare);
      n_count = m_tick ? m_count + 32'd1 : m_count;
      if (wr && a == 5'd11)  m_cause = m_cause & ~32'h40008000;
      else if (match)        m_cause = m_cause | 32'h40008000;
      if (wr) begin
         case (a)
            5'd9:  n_count = wd;
            5'd11: m_compare = wd;
            5'd12: m_status = 32'h00400000 | (wd & 32'h0000FF03);
            5'd13: m_cause = (m_cause & ~32'h00000300) | (wd & 32'h00000300);
            5'd14: m_epc = wd;
            default: ;
         endcase
      end
      if (exc) begin
         m_epc = m_bus[31:0];
         m_cause = (m_cause & ~32'h0000007C) | {25'd0, m_bus[106:102], 2'b00};
         m_status = m_status | 32'h2;
      end
      m_count = n_count;
      m_tick  = ~m_tick;
      m_valid = v;
      if (v) m_bus = b;
   endtask

   task automatic check_outputs();
      logic        e_we;
      logic [31:0] e_wd;
      e_we = m_valid && m_bus[101] && !m_bus[107];
      e_wd = m_bus[140] ? cp0_read(m_bus[145:141]) : m_bus[95:64];
      chk("allowin", {31'd0, bus.ws_allowin}, 32'd1);
      chk("rf_we", {31'd0, rf_we}, {31'd0, e_we});
      chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_bus[100:96]});
      chk("rf_wdata", rf_wdata, e_wd);
      chk("ws_ex", {31'd0, ws_ex}, {31'd0, m_valid && m_bus[107]});
      chk("ws_ex_pc", ws_ex_pc, 32'hbfc00380);
      chk("int_req", {31'd0, int_req},
          {31'd0, m_status[0] && !m_status[1] && |(m_cause[15:8] & m_status[15:8])});
      chk("dbg_pc", debug_wb_pc, m_bus[31:0]);
      chk("dbg_wen", {28'd0, debug_wb_rf_wen}, {28'd0, {4{e_we}}});
      chk("dbg_wnum", {27'd0, debug_wb_rf_wnum}, {27'd0, m_bus[100:96]});
      chk("dbg_wdata", debug_wb_rf_wdata, e_wd);
   endtask

   task automatic cycle(input logic rst, input logic v, input logic [146:0] b);
      reset = rst;
      bus.ms_to_ws_valid = v;
      bus.ms_to_ws_bus = b;
      @(posedge clk);
      model_edge(rst, v, b);
      #1;
      check_outputs();
   endtask

   task automatic bubble();
      cycle(1'b0, 1'b0, mk(1'b0, 5'd0, 1'b0, $urandom, 1'b0, 5'd0, 1'b0, 5'd0, $urandom, $urandom, $urandom));
   endtask

   task automatic mtc0(input logic [4:0] addr, input logic [31:0] wd);
      cycle(1'b0, 1'b1, mk(1'b1, addr, 1'b0, $urandom, 1'b0, 5'd0, 1'b0, 5'd0, $urandom, wd, $urandom));
   endtask

   task automatic mfc0(input logic [4:0] addr, input logic [4:0] dest);
      cycle(1'b0, 1'b1, mk(1'b0, addr, 1'b1, $urandom, 1'b0, 5'd0, 1'b1, dest, $urandom, $urandom, $urandom));
   endtask

   initial begin
      logic found;
      logic [4:0] addr_tab [6];
      reset = 1'b1;
      bus.ms_to_ws_valid = 1'b0;
      bus.ms_to_ws_bus = '0;

      // Reset state
      cycle(1'b1, 1'b0, '0);
      cycle(1'b1, 1'b1, mk(1'b0, 5'd0, 1'b0, 32'd1, 1'b0, 5'd0, 1'b1, 5'd2, 32'd3, 32'd4, 32'h5));
      chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
      chk("rst_dbg_pc", debug_wb_pc, 32'd0);
      chk("rst_ws_ex", {31'd0, ws_ex}, 32'd0);
      chk("rst_int_req", {31'd0, int_req}, 32'd0);

      // MTC0 Status all ones, then read back
      mtc0(5'd12, 32'hFFFFFFFF);
      chk("mtc0_no_rf_we", {31'd0, rf_we}, 32'd0);
      mfc0(5'd12, 5'd3);
      chk("status_rd", rf_wdata, 32'h0040FF03);

      // Load commit
      cycle(1'b0, 1'b1, mk(1'b0, 5'd0, 1'b0, $urandom, 1'b0, 5'd0, 1'b1, 5'd5, 32'h1234, $urandom, 32'hbfc00040));
      chk("load_we", {31'd0, rf_we}, 32'd1);
      chk("load_waddr", {27'd0, rf_waddr}, 32'd5);
      chk("load_wdata", rf_wdata, 32'h1234);
      chk("load_wen", {28'd0, debug_wb_rf_wen}, 32'hF);

      // Exception with both rf and CP0 writes requested
      cycle(1'b0, 1'b1, mk(1'b1, 5'd12, 1'b0, $urandom, 1'b1, 5'h0C, 1'b1, 5'd7, $urandom, 32'd0, 32'hbfc00100));
      chk("exc_ws_ex", {31'd0, ws_ex}, 32'd1);
      chk("exc_rf_we", {31'd0, rf_we}, 32'd0);
      mfc0(5'd14, 5'd1);
      chk("exc_epc", rf_wdata, 32'hbfc00100);
      mfc0(5'd13, 5'd1);
      chk("exc_code", {27'd0, rf_wdata[6:2]}, 32'h0C);
      mfc0(5'd12, 5'd1);
      chk("exc_status", rf_wdata, 32'h0040FF03);

      // Timer interrupt
      mtc0(5'd12, 32'h00408001);
      mtc0(5'd11, 32'd4);
      mtc0(5'd9, 32'd0);
      found = 1'b0;
      for (int i = 0; i < 24 && !found; i++) begin
         bubble();
         if (int_req === 1'b1) found = 1'b1;
      end
      chk("timer_int_seen", {31'd0, found}, 32'd1);
      mfc0(5'd13, 5'd2);
      chk("timer_ti", {30'd0, rf_wdata[30], rf_wdata[15]}, 32'd3);
      mtc0(5'd11, 32'h00000100);
      bubble();
      chk("timer_int_clr", {31'd0, int_req}, 32'd0);
      mfc0(5'd13, 5'd2);
      chk("timer_ti_clr", {31'd0, rf_wdata[30]}, 32'd0);

      // Count write on an increment cycle
      if (m_tick) bubble();
      mtc0(5'd9, 32'h10);
      mfc0(5'd9, 5'd4);
      chk("count_override", rf_wdata, 32'h10);

      // Randomized traffic
      addr_tab = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};
      for (int i = 0; i < 400; i++) begin
         logic [4:0] a;
         a = addr_tab[$urandom_range(0, 5)];
         if (a == 5'd0) a = 5'($urandom_range(0, 31));
         cycle(1'b0, $urandom_range(0, 3) != 0,
               mk(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)), $urandom,
                  $urandom_range(0, 7) == 0, 5'($urandom), 1'($urandom_range(0, 1)),
                  5'($urandom), $urandom, $urandom, $urandom));
      end

      // Reset asserted mid-stream
      mtc0(5'd14, 32'hdeadbeef);
      cycle(1'b0, 1'b1, mk(1'b0, 5'd0, 1'b0, $urandom, 1'b0, 5'd0, 1'b1, 5'd9, 32'h55, $urandom, 32'hbfc00200));
      cycle(1'b1, 1'b1, mk(1'b0, 5'd0, 1'b0, $urandom, 1'b0, 5'd0, 1'b1, 5'd10, 32'h66, $urandom, 32'hbfc00204));
      chk("rst_mid_rf_we", {31'd0, rf_we}, 32'd0);
      mfc0(5'd12, 5'd6);
      chk("rst_mid_status", rf_wdata, 32'h00400000);
      mfc0(5'd14, 5'd6);
      chk("rst_mid_epc", rf_wdata, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
